// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : booth_mul_seq
//  Purpose  : Sequential signed radix-2 Booth multiplier, one step per clock,
//             with a start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int                 c_cnt_w     = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     mq_q, mq_d;
    logic                 q1_q, q1_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH:0]       w_acc_op;
    logic [WIDTH:0]       w_acc_sh;
    logic [WIDTH-1:0]     w_mq_sh;
    logic                 w_q1_sh;

    // One Booth step: add/subtract M, then arithmetic shift of {A, Q, q_1}.
    // A and M carry an extra bit so that subtracting the most negative
    // operand cannot overflow.
    always_comb begin
        case ({mq_q[0], q1_q})
            2'b01:   w_acc_op = acc_q + m_q;
            2'b10:   w_acc_op = acc_q - m_q;
            default: w_acc_op = acc_q;
        endcase
        w_acc_sh = {w_acc_op[WIDTH], w_acc_op[WIDTH:1]};
        w_mq_sh  = {w_acc_op[0], mq_q[WIDTH-1:1]};
        w_q1_sh  = mq_q[0];
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    m_d     = {a[WIDTH-1], a};
                    acc_d   = '0;
                    mq_d    = b;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                acc_d = w_acc_sh;
                mq_d  = w_mq_sh;
                q1_d  = w_q1_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_last_step) begin
                    state_d = S_DONE;
                    p_d     = {w_acc_sh[WIDTH-1:0], w_mq_sh};
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = S_RUN;
                    m_d     = {a[WIDTH-1], a};
                    acc_d   = '0;
                    mq_d    = b;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign p = p_q;

endmodule
`default_nettype wire

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Sequential signed radix-2 Booth multiplier. It is the inverse-direction companion to the non-restoring divider datapath.
- It rebuilds a dividend-sized product from a quotient and divisor (q*m) for divider self-check, and also serves as a general-purpose signed multiply.
- Retires one Booth step per clock and uses a start/busy/done handshake.
- It sits beside the divider and consumes its quotient and divisor outputs.

Parameters:
- WIDTH, 8, operand width in bits. Product width is 2*WIDTH. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply. Sampled only while the block is ready (IDLE or DONE).
- a  input  WIDTH  signed multiplicand (the divisor m when self-checking). Two's complement.
- b  input  WIDTH  signed multiplier (the quotient q when self-checking). Two's complement.
- busy  output  1  high while an operation is in progress. start is ignored while busy=1.
- done  output  1  one-cycle pulse when p has just become valid.
- p  output  2*WIDTH  signed product a*b. Holds its value until the next accepted start.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, p=0, all internal registers=0. Reset takes priority over start and aborts any operation in progress. No done pulse is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1, load the operands, clear the step counter and go to RUN.
  - Multiplicand register M = a, sign-extended to WIDTH+1 bits.
  - Accumulator A = 0, WIDTH+1 bits.
  - Q = b.
  - Booth bit q_1 = 0.
- RUN: busy=1, done=0. Each cycle performs one Booth step.
  - Examine {Q[0], q_1}: 01 -> A = A + M; 10 -> A = A - M; 00 and 11 -> A unchanged.
  - Then arithmetic-shift the {A, Q, q_1} combination right by 1. The MSB of A is replicated.
  - Increment the counter. After the WIDTH-th step go to DONE.
- Arithmetic width rule: A and M are WIDTH+1 bits so that subtracting the most negative operand (e.g. -128 for WIDTH=8) cannot overflow.
- DONE: latch p = {A[WIDTH-1:0], Q}, i.e. the low 2*WIDTH bits of {A, Q}. In this cycle done=1 and busy=0.
  - If start=1 in this same cycle, the new operands load and the state goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: a start accepted at edge k gives busy=1 from edge k+1. done=1 for exactly one cycle beginning at edge k+WIDTH+1, and p is valid from that edge.
- Throughput: one product per WIDTH+1 cycles when starts are back to back.
- start held high continuously re-launches an operation every WIDTH+1 cycles.
- a and b are sampled only at the accepting edge. Changes to them during RUN have no effect.
- p does not change during RUN; the previous result stays visible until the DONE edge.
- The result is exact for all operand pairs. No saturation and no overflow flag; the full range fits in 2*WIDTH bits.

Test Plan:
- Reset, then a=7, b=3, pulse start.
  - busy rises the next cycle.
  - done pulses 9 edges after start; p=21 (0x0015).
  - busy=0 in the done cycle.
- a=-128, b=-128 -> p=16384 (0x4000). Then a=-128, b=127 -> p=-16256 (0xC080). This confirms the WIDTH+1 accumulator is present.
- Divider self-check: q=-4, m=3 -> p=-12 (0xFFF4). Then a=0, b=-1 -> p=0. Then a=-1, b=-1 -> p=1.
- Back-to-back: hold start=1 with operand pairs (5,5) then (-6,7).
  - done pulses at edges k+9 and k+18 with p=25, then p=-42.
  - p holds 25 through the second RUN phase.
- start pulsed and a/b changed mid-RUN:
  - There is no restart and the result uses the originally sampled operands.
  - After done, with start low, the block returns to IDLE and p holds.
- Assert rst at step 4 of RUN:
  - Next edge shows busy=0, done=0, p=0, and no done pulse appears afterwards.
  - A new start then completes normally (e.g. 12*-11 -> -132).
